grant_sequencer: RTL
====================

# grant_sequencer

Round-robin arbiter and sequencer that shares a single one-hot select resource (the 3-to-8 / 6-to-64 decoder path) among N requesters. Each cycle at most one requester owns the resource. The block drives the binary select index and enable into the decoder and also outputs the equivalent one-hot grant. Ownership is held until the owner releases it, then passes to the next requester in rotating order.

## Interface
- N, 8, number of requesters; power of two, 2..64
- W, $clog2(N), width of the select index (derived; do not override)
- TIMEOUT, 16, maximum grant hold in cycles when the timeout feature is compiled in; range 2..255
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  arbitration enable; gates new grants only
- req  in  N  request vector; bit i is held high while requester i wants the resource
- done  in  1  release pulse from the current owner
- gnt  out  N  one-hot grant, registered; all zeros when idle
- gnt_idx  out  W  binary index of the owner; drives the decoder select; 0 when idle
- gnt_valid  out  1  high while a grant is held; drives the decoder enable
- timeout  out  1  one-cycle pulse on a forced release

## Operation
- Two states.
  - IDLE (reset state).
  - GRANT.
- Rotation pointer ptr (W bits) resets to 0.
- IDLE:
  - If en=1 and req≠0, select the first set bit of req, searching from ptr upward with wrap-around modulo N.
  - Load gnt, gnt_idx and gnt_valid with the selection and go to GRANT.
  - If en=0 or req=0, stay in IDLE with outputs at zero.
  - done is ignored in IDLE.
- GRANT:
  - Outputs stay constant.
  - Release occurs when done=1, or when req[gnt_idx]=0 (the requester withdrew), or when a timeout fires.
  - On release:
    - ptr <= gnt_idx+1 (wraps from N-1 to 0).
    - gnt, gnt_idx and gnt_valid return to 0.
    - Next state is IDLE.
  - en=0 does not revoke a grant in progress.
  - Simultaneous done and a withdrawn req count as a single release.
- req changes on bits other than the owner's have no effect in GRANT.
- Invariants:
  - gnt is always zero or one-hot.
  - gnt == (gnt_valid << gnt_idx).
  - gnt_valid == |gnt.

## Timing
- Reset values:
  - gnt=0, gnt_idx=0, gnt_valid=0, timeout=0.
  - ptr=0, state IDLE, hold counter 0.
- Reset is asynchronous: asserting rst_n mid-grant clears all outputs immediately, without waiting for a clock edge.
- Grant latency: req sampled at edge k while in IDLE gives gnt visible after edge k (1 cycle).
- Release latency: done sampled at edge k gives gnt=0 after edge k.
- A mandatory IDLE cycle follows every release. The earliest next grant appears after edge k+1.
- Back-to-back requests from two requesters therefore see at least one dead cycle between grants.
- Minimum grant length is 1 cycle (done sampled on the first GRANT cycle).

## Configuration
- GRANT_TIMEOUT_EN defined:
  - An 8-bit hold counter clears on entry to GRANT and increments every GRANT cycle.
  - If the grant has lasted TIMEOUT cycles with no other release, a forced release occurs on that edge.
  - timeout pulses high for exactly 1 cycle, aligned with gnt going to 0.
  - ptr advances as for a normal release.
  - If done and the timeout coincide, the release is normal and timeout stays 0.
- GRANT_TIMEOUT_EN undefined:
  - No counter is built.
  - timeout is tied to 0.
  - A grant is held indefinitely until done or req withdrawal.

## Test plan
- Reset mid-grant: with requester 5 granted, pull rst_n low between edges -> gnt=0, gnt_valid=0 immediately; after reset, req=8'h20 -> gnt=8'h20, gnt_idx=5.
- Rotation: req=8'hFF held, done pulsed on every GRANT cycle -> grant order 0,1,2,…,7,0; one IDLE cycle between each grant.
- Fairness skip: ptr=3, req=8'h05 -> gnt_idx=0 (wrap past 3..7); after release, ptr=1 and the next grant is to 2.
- Enable and withdrawal: en=0, req=8'h10 -> no grant. Set en=1 -> gnt=8'h10 after 1 edge. Set en=0 during GRANT -> grant kept. Drop req[4] -> release on that edge.
- Timeout (macro on, TIMEOUT=16): req=8'h02, done never asserted -> gnt_valid high for exactly 16 cycles, then timeout=1 for 1 cycle, then a regrant to 1 after the IDLE cycle.
- Timeout coincidence (macro on): done asserted on cycle 16 -> timeout stays 0; macro off, same stimulus with no done -> grant held for more than 100 cycles.

Source files
------------

// File: rtl/grant_sequencer.sv
// Round-robin grant sequencer: one owner of the shared decoder select at a time.
// Optional forced release after TIMEOUT held cycles when GRANT_TIMEOUT_EN is defined.
module grant_sequencer #(
    parameter int N       = 8,
    parameter int W       = $clog2(N),
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [N-1:0] req,
    input  logic         done,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx,
    output logic         gnt_valid,
    output logic         timeout,
    output logic         state_dbg
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam bit TIMEOUT_LEGAL = (TIMEOUT >= 2) && (TIMEOUT <= 255);

    state_t         state_q, state_d;
    logic [W-1:0]   ptr_q;
    logic [W-1:0]   idx_q;
    logic           timeout_q;
    logic [W-1:0]   sel_idx;
    logic [W-1:0]   cand;
    logic           sel_hit;
    logic           normal_rel;
    logic           force_rel;
    logic           rel;

    // First requester at or after ptr; W-bit addition gives the modulo-N wrap.
    always_comb begin
        sel_idx = '0;
        sel_hit = 1'b0;
        cand    = '0;
        for (int i = 0; i < N; i++) begin
            cand = ptr_q + W'(i);
            if (!sel_hit && req[cand]) begin
                sel_hit = 1'b1;
                sel_idx = cand;
            end
        end
    end

    assign normal_rel = done | ~req[idx_q];

`ifdef GRANT_TIMEOUT_EN
    logic [7:0] cnt_q;
    logic       expire;

    assign expire    = TIMEOUT_LEGAL && (cnt_q == 8'(TIMEOUT - 1));
    assign force_rel = expire & ~normal_rel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else if (state_q == GRANT) begin
            cnt_q <= cnt_q + 8'd1;
        end else begin
            cnt_q <= 8'd0;
        end
    end
`else
    assign force_rel = 1'b0 && TIMEOUT_LEGAL;
`endif

    assign rel = normal_rel | force_rel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en && sel_hit) state_d = GRANT;
            GRANT:   if (rel)           state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // Owner index is cleared on release so gnt_idx reads 0 while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q     <= '0;
            ptr_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= (state_q == GRANT) && force_rel;
            if (state_q == IDLE && state_d == GRANT) begin
                idx_q <= sel_idx;
            end else if (state_q == GRANT && rel) begin
                idx_q <= '0;
                ptr_q <= idx_q + W'(1);
            end
        end
    end

    always_comb begin
        gnt_valid = (state_q == GRANT);
        gnt_idx   = idx_q;
        gnt       = '0;
        if (gnt_valid) gnt = N'(1) << idx_q;
        timeout   = timeout_q;
        state_dbg = state_q;
    end

endmodule
